// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings (opcode[2:0]) and write-back FSM states.
package mips_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks byte/half/word from a read word and sign- or zero-extends it.
// Zero latency; no handshake, purely a function of its inputs.
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Halfword loads ignore off[0]; misalignment is not trapped here.
    half_sel = off[1] ? word[31:16] : word[15:0];

    data = word;
    case (load_type)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'd0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage driving the GPR write port; non-loads write 1 cycle after accept,
// loads write 1 cycle after the memory response. m_ready drops while a load waits for data.
module wb_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic        m_we,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_result,
  input  logic        m_is_load,
  input  logic [2:0]  m_load_type,
  input  logic [1:0]  m_addr_lo,
  input  logic        dresp_valid,
  input  logic [31:0] dresp_data,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        stall_W,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        resp_err
);

  wb_state_e   state_q;
  wb_state_e   state_d;
  logic        accept;
  logic        ld_we_q;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  ld_off_q;
  logic [31:0] aligned;

  load_align u_load_align (
    .load_type (ld_type_q),
    .off       (ld_off_q),
    .word      (dresp_data),
    .data      (aligned)
  );

  always_comb begin
    state_d = state_q;
    m_ready = 1'b0;
    case (state_q)
      IDLE: begin
        m_ready = 1'b1;
        if (m_valid && m_is_load) state_d = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (dresp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = m_valid && m_ready;

  // ld_we_q already folds in rd!=0, so busy never advertises a hazard on r0.
  assign busy    = (state_q == WAIT_LOAD) && ld_we_q;
  assign busy_rd = busy ? ld_rd_q : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we        <= 1'b0;
      wa        <= 5'd0;
      wd        <= 32'd0;
      stall_W   <= 1'b0;
      resp_err  <= 1'b0;
      ld_we_q   <= 1'b0;
      ld_rd_q   <= 5'd0;
      ld_type_q <= 3'd0;
      ld_off_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      stall_W <= (state_d == WAIT_LOAD);
      we      <= 1'b0;

      if (state_q == IDLE && dresp_valid) resp_err <= 1'b1;

      if (accept && !m_is_load) begin
        we <= m_we && (m_rd != 5'd0);
        wa <= m_rd;
        wd <= m_result;
      end

      if (accept && m_is_load) begin
        ld_we_q   <= m_we && (m_rd != 5'd0);
        ld_rd_q   <= m_rd;
        ld_type_q <= m_load_type;
        ld_off_q  <= m_addr_lo;
      end

      if (state_q == WAIT_LOAD && dresp_valid) begin
        we <= ld_we_q;
        wa <= ld_rd_q;
        wd <= aligned;
      end
    end
  end

endmodule
